lcd_16207_sequencer: RTL and testbench

Timing-correct bus sequencer for the 16207 (HD44780-class) character LCD. Sits between an Avalon-MM slave port and the LCD pins. It stretches each CPU access into a full LCD bus cycle with programmed setup, enable-pulse, hold and recovery times. After every write it can optionally poll the busy flag, so software never needs delay loops.

---
 rtl/lcd_16207_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_lcd_16207_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_16207_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_16207_sequencer
//  Brief    : Avalon-MM to 16207/HD44780 LCD bus sequencer. Stretches each
//             CPU access into a timed setup/enable/hold/recovery cycle and
//             optionally polls the busy flag after every write.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_16207_sequencer #(
  parameter int SETUP_CYCLES = 3,
  parameter int PULSE_CYCLES = 13,
  parameter int HOLD_CYCLES  = 2,
  parameter int GAP_CYCLES   = 7,
  parameter int POLL_BUSY    = 1,
  parameter int POLL_MAX     = 4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       busy_timeout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0]  C_SETUP    = 8'(SETUP_CYCLES);
  localparam logic [7:0]  C_PULSE    = 8'(PULSE_CYCLES);
  localparam logic [7:0]  C_HOLD     = 8'(HOLD_CYCLES);
  localparam logic [7:0]  C_GAP      = 8'(GAP_CYCLES);
  localparam logic [15:0] C_POLL_MAX = 16'(POLL_MAX);
  localparam logic        C_POLL_EN  = (POLL_BUSY != 0);

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;        // cycles left in the current phase
  logic [15:0] poll_cnt_q, poll_cnt_d;  // number of poll cycles issued so far
  logic        poll_q, poll_d;          // current bus cycle is a busy-flag poll
  logic        is_wr_q, is_wr_d;        // latched transfer direction
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  readdata_q, readdata_d;
  logic        db7_q, db7_d;            // busy flag seen by the last poll
  logic        timeout_q, timeout_d;
  logic        e_q, e_d;
  logic        rs_q, rs_d;
  logic        rw_q, rw_d;
  logic        oe_q, oe_d;
  logic        phase_last;

  // Next-state, phase counting, capture and pin values for the next cycle
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    poll_cnt_d = poll_cnt_q;
    poll_d     = poll_q;
    is_wr_d    = is_wr_q;
    wdata_d    = wdata_q;
    readdata_d = readdata_q;
    db7_d      = db7_q;
    timeout_d  = timeout_q;
    e_d        = e_q;
    rs_d       = rs_q;
    rw_d       = rw_q;
    oe_d       = oe_q;
    phase_last = (phase_q == 8'd1);

    case (state_q)
      S_IDLE: begin
        if (read || write) begin
          is_wr_d    = write;
          wdata_d    = writedata;
          timeout_d  = 1'b0;
          poll_d     = 1'b0;
          poll_cnt_d = 16'd0;
          rs_d       = address[1];
          // address[0] only matters for reads; a write is always RW = 0
          rw_d       = write ? 1'b0 : address[0];
          oe_d       = write;
          phase_d    = C_SETUP;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        phase_d = phase_q - 8'd1;
        if (phase_last) begin
          e_d     = 1'b1;
          phase_d = C_PULSE;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        phase_d = phase_q - 8'd1;
        if (phase_last) begin
          // Sample the bus on the final enable cycle, just before E falls
          if (poll_q) begin
            db7_d = LCD_data[7];
          end else if (!is_wr_q) begin
            readdata_d = LCD_data;
          end
          e_d     = 1'b0;
          phase_d = C_HOLD;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        phase_d = phase_q - 8'd1;
        if (phase_last) begin
          oe_d    = 1'b0;
          rw_d    = 1'b1;
          phase_d = C_GAP;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        phase_d = phase_q - 8'd1;
        if (phase_last) begin
          if (!poll_q && is_wr_q && C_POLL_EN) begin
            poll_d     = 1'b1;
            poll_cnt_d = 16'd1;
            rs_d       = 1'b0;
            rw_d       = 1'b1;
            phase_d    = C_SETUP;
            state_d    = S_SETUP;
          end else if (poll_q && db7_q && (poll_cnt_q < C_POLL_MAX)) begin
            poll_cnt_d = poll_cnt_q + 16'd1;
            rs_d       = 1'b0;
            rw_d       = 1'b1;
            phase_d    = C_SETUP;
            state_d    = S_SETUP;
          end else begin
            if (poll_q && db7_q) begin
              timeout_d = 1'b1;
            end
            rs_d    = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and pin registers; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= 8'd0;
      poll_cnt_q <= 16'd0;
      poll_q     <= 1'b0;
      is_wr_q    <= 1'b0;
      wdata_q    <= 8'd0;
      readdata_q <= 8'd0;
      db7_q      <= 1'b0;
      timeout_q  <= 1'b0;
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b1;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      poll_cnt_q <= poll_cnt_d;
      poll_q     <= poll_d;
      is_wr_q    <= is_wr_d;
      wdata_q    <= wdata_d;
      readdata_q <= readdata_d;
      db7_q      <= db7_d;
      timeout_q  <= timeout_d;
      e_q        <= e_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
    end
  end

  assign waitrequest  = (read | write) & (state_q != S_DONE);
  assign readdata     = readdata_q;
  assign busy_timeout = timeout_q;
  assign LCD_E        = e_q;
  assign LCD_RS       = rs_q;
  assign LCD_RW       = rw_q;
  assign LCD_data     = oe_q ? wdata_q : 8'bz;

endmodule
`default_nettype wire

// File: tb/tb_lcd_16207_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_lcd_16207_sequencer
//  Brief    : Self-checking bench for lcd_16207_sequencer. Instance 0 runs
//             without busy polling, instance 1 polls with a limit of 8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_16207_sequencer;

  localparam int S     = 3;
  localparam int P     = 13;
  localparam int H     = 2;
  localparam int G     = 7;
  localparam int T     = S + P + H + G;
  localparam int PMAX1 = 8;

  typedef struct {
    int         k;
    logic       wr;
    logic [1:0] a;
    logic [7:0] wd;
    int         busy;
    logic [7:0] rv;
    int         lat;
    int         pulses;
    logic       to;
    logic [7:0] rd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_s  [2];
  logic       rd_s   [2];
  logic       wr_s   [2];
  logic [1:0] addr_s [2];
  logic [7:0] wd_s   [2];
  logic [7:0] rdd_s  [2];
  logic       wreq_s [2];
  logic       bto_s  [2];
  logic       e_s    [2];
  logic       rs_s   [2];
  logic       rw_s   [2];
  wire  [7:0] lcd_bus0;
  wire  [7:0] lcd_bus1;
  logic [7:0] bus_v  [2];

  // LCD model state: busy polls left and the byte it returns on reads
  int         busy_left [2];
  logic [7:0] mdl_rd    [2];
  logic [7:0] rd_model  [2];
  int         last_rise_abs [2];
  int         abs_cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #10 clk = ~clk;

  always @(posedge clk) abs_cyc <= abs_cyc + 1;

  // Byte an HD44780 puts on the bus: RS=0 returns busy flag in DB7
  function automatic logic [7:0] lcd_val(input logic rs, input int bl, input logic [7:0] rv);
    if (rs) return rv;
    return (bl > 0) ? (rv | 8'h80) : (rv & 8'h7F);
  endfunction

  assign lcd_bus0 = rw_s[0] ? lcd_val(rs_s[0], busy_left[0], mdl_rd[0]) : 8'bz;
  assign lcd_bus1 = rw_s[1] ? lcd_val(rs_s[1], busy_left[1], mdl_rd[1]) : 8'bz;
  assign bus_v[0] = lcd_bus0;
  assign bus_v[1] = lcd_bus1;

  // Each completed busy read consumes one busy report
  always @(negedge e_s[0]) if (!rs_s[0] && rw_s[0] && busy_left[0] > 0) busy_left[0] = busy_left[0] - 1;
  always @(negedge e_s[1]) if (!rs_s[1] && rw_s[1] && busy_left[1] > 0) busy_left[1] = busy_left[1] - 1;

  lcd_16207_sequencer #(.POLL_BUSY(0)) u_nopoll (
    .clk(clk), .reset(rst_s[0]), .address(addr_s[0]), .read(rd_s[0]), .write(wr_s[0]),
    .writedata(wd_s[0]), .readdata(rdd_s[0]), .waitrequest(wreq_s[0]),
    .busy_timeout(bto_s[0]), .LCD_E(e_s[0]), .LCD_RS(rs_s[0]), .LCD_RW(rw_s[0]),
    .LCD_data(lcd_bus0)
  );

  lcd_16207_sequencer #(.POLL_BUSY(1), .POLL_MAX(PMAX1)) u_poll (
    .clk(clk), .reset(rst_s[1]), .address(addr_s[1]), .read(rd_s[1]), .write(wr_s[1]),
    .writedata(wd_s[1]), .readdata(rdd_s[1]), .waitrequest(wreq_s[1]),
    .busy_timeout(bto_s[1]), .LCD_E(e_s[1]), .LCD_RS(rs_s[1]), .LCD_RW(rw_s[1]),
    .LCD_data(lcd_bus1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: number of busy polls a transfer triggers
  function automatic int n_polls(input int k, input logic wr, input int busy);
    if (!wr || k == 0) return 0;
    if (busy >= PMAX1) return PMAX1;
    return busy + 1;
  endfunction

  // One Avalon transfer, entered and left just after a rising edge
  task automatic xfer(input int k, input logic wr, input logic [1:0] a, input logic [7:0] wd,
                      input int busy, input logic [7:0] rv, input int elat, input int epul,
                      input logic eto, input logic [7:0] erd);
    int   lat        = -1;
    int   pulses     = 0;
    int   first_rise = -1;
    int   width      = 0;
    logic kind_ok    = 1'b1;
    logic data_ok    = 1'b1;
    logic prev_e     = 1'b0;
    busy_left[k] = busy;
    mdl_rd[k]    = rv;
    addr_s[k]    = a;
    wd_s[k]      = wd;
    wr_s[k]      = wr;
    rd_s[k]      = !wr;
    #1;
    chk("wait_at_request", int'(wreq_s[k]), 1);
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("timeout_cleared_on_accept", int'(bto_s[k]), 0);
      if (e_s[k] && !prev_e) begin
        pulses++;
        if (pulses == 1) begin
          first_rise       = c;
          last_rise_abs[k] = abs_cyc;
          if (rs_s[k] !== a[1] || rw_s[k] !== (wr ? 1'b0 : a[0])) kind_ok = 1'b0;
        end else if (rs_s[k] !== 1'b0 || rw_s[k] !== 1'b1) begin
          kind_ok = 1'b0;
        end
      end
      if (e_s[k] && pulses == 1) width++;
      if (wr && c <= S + P + H)
        if (bus_v[k] !== wd || rw_s[k] !== 1'b0 || rs_s[k] !== a[1]) data_ok = 1'b0;
      prev_e = e_s[k];
      if (!wreq_s[k]) begin
        lat = c;
        break;
      end
    end
    chk("done_cycle", lat, elat);
    chk("enable_pulses", pulses, epul);
    chk("first_e_rise", first_rise, S + 1);
    chk("first_e_width", width, P);
    chk("rs_rw_per_cycle", int'(kind_ok), 1);
    if (wr) chk("write_data_window", int'(data_ok), 1);
    chk("busy_timeout", int'(bto_s[k]), int'(eto));
    chk("readdata_at_done", int'(rdd_s[k]), int'(erd));
    wr_s[k] = 1'b0;
    rd_s[k] = 1'b0;
    @(posedge clk); #1;
    chk("readdata_held", int'(rdd_s[k]), int'(erd));
  endtask

  vec_t tbl [10];

  initial begin
    int prev_rise;
    int k, busy, np;
    logic wr;
    logic [1:0] a;
    logic [7:0] wd, rv;

    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1; rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 2'd0; wd_s[i] = 8'd0;
      busy_left[i] = 0; mdl_rd[i] = 8'h00; rd_model[i] = 8'h00; last_rise_abs[i] = 0;
    end

    tbl[0] = '{0, 1'b1, 2'd0, 8'h38, 0,   8'h00, 26,  1, 1'b0, 8'h00};
    tbl[1] = '{0, 1'b0, 2'd3, 8'h00, 0,   8'h5A, 26,  1, 1'b0, 8'h5A};
    tbl[2] = '{1, 1'b1, 2'd0, 8'h01, 3,   8'h11, 126, 5, 1'b0, 8'h00};
    tbl[3] = '{1, 1'b1, 2'd0, 8'h55, 100, 8'h22, 226, 9, 1'b1, 8'h00};
    tbl[4] = '{1, 1'b0, 2'd3, 8'h00, 0,   8'h5A, 26,  1, 1'b0, 8'h5A};
    tbl[5] = '{1, 1'b1, 2'd2, 8'h20, 0,   8'h33, 51,  2, 1'b0, 8'h5A};
    tbl[6] = '{0, 1'b1, 2'd0, 8'h01, 0,   8'h00, 26,  1, 1'b0, 8'h5A};
    tbl[7] = '{0, 1'b1, 2'd0, 8'h0C, 0,   8'h00, 26,  1, 1'b0, 8'h5A};
    tbl[8] = '{0, 1'b1, 2'd1, 8'h77, 0,   8'h00, 26,  1, 1'b0, 8'h5A};
    tbl[9] = '{0, 1'b0, 2'd1, 8'h00, 0,   8'hC3, 26,  1, 1'b0, 8'h43};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_lcd_e",   int'(e_s[i]),   0);
      chk("reset_lcd_rs",  int'(rs_s[i]),  0);
      chk("reset_lcd_rw",  int'(rw_s[i]),  1);
      chk("reset_readdata", int'(rdd_s[i]), 0);
      chk("reset_timeout", int'(bto_s[i]), 0);
      chk("reset_waitreq", int'(wreq_s[i]), 0);
    end
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      prev_rise = last_rise_abs[tbl[i].k];
      xfer(tbl[i].k, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].busy, tbl[i].rv,
           tbl[i].lat, tbl[i].pulses, tbl[i].to, tbl[i].rd);
      rd_model[tbl[i].k] = tbl[i].rd;
      if (i == 7) chk("back_to_back_spacing_ok", int'(last_rise_abs[0] - prev_rise >= T + 1), 1);
    end

    // Reset in the middle of an enable pulse
    mdl_rd[0]    = 8'h3C;
    busy_left[0] = 0;
    addr_s[0]    = 2'd0;
    wd_s[0]      = 8'hAA;
    wr_s[0]      = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("e_high_before_reset", int'(e_s[0]), 1);
    rst_s[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_pulse_e",     int'(e_s[0]),    0);
    chk("rst_mid_pulse_rw",    int'(rw_s[0]),   1);
    chk("rst_mid_pulse_wait",  int'(wreq_s[0]), 1);
    chk("rst_mid_pulse_bus",   int'(bus_v[0]),  int'(8'h3C));
    chk("rst_mid_pulse_rdata", int'(rdd_s[0]),  0);
    rst_s[0] = 1'b0;
    wr_s[0]  = 1'b0;
    rd_model[0] = 8'h00;
    @(posedge clk); #1;
    xfer(0, 1'b1, 2'd0, 8'h38, 0, 8'h00, T + 1, 1, 1'b0, rd_model[0]);

    // Randomized transfers against the reference model
    for (int i = 0; i < 30; i++) begin
      k    = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      a    = 2'($urandom);
      wd   = 8'($urandom);
      rv   = 8'($urandom);
      busy = wr ? int'($urandom_range(0, 11)) : 0;
      if (!wr) begin
        a[0] = 1'b1;
        rd_model[k] = a[1] ? rv : (rv & 8'h7F);
      end
      np = n_polls(k, wr, busy);
      xfer(k, wr, a, wd, busy, rv, T * (1 + np) + 1, 1 + np,
           (np == PMAX1) && (busy >= PMAX1), rd_model[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
